// File: rtl/axi_cache_refill_master.sv
// Cache-line refill master: bus request, a single AXI read burst per line, then the line is returned with a done pulse.
// Optional build macro CRITICAL_WORD_FIRST_EN: WRAP burst from the missed word, plus crit_valid/crit_data outputs.
module axi_cache_refill_master #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] ARID_VAL   = 4'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_valid,
    input  logic [31:0]              miss_addr,
    output logic                     miss_ready,
    output logic                     refill_done,
    output logic [32*LINE_WORDS-1:0] refill_line,
    output logic                     refill_err,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic                     crit_valid,
    output logic [31:0]              crit_data,
`endif
    output logic                     req,
    input  logic                     grnt,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int CNT_W  = WORD_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]              r_state;
    logic [31:0]             r_addr;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;
    logic [32*LINE_WORDS-1:0] r_line;

    logic [WORD_W-1:0]       w_start;
    logic [WORD_W-1:0]       w_slot;
    logic                    w_beat;
    logic                    w_unused;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start  = r_addr[OFF_W-1:2];
    assign araddr   = {r_addr[31:2], 2'b00};
    assign arburst  = 2'b10;
    assign w_unused = ^{rid, r_addr[1:0]};
`else
    assign w_start  = '0;
    assign araddr   = {r_addr[31:OFF_W], OFF_W'(0)};
    assign arburst  = 2'b01;
    assign w_unused = ^{rid, r_addr[OFF_W-1:0]};
`endif

    // Slot index wraps naturally through the WORD_W-bit truncation.
    assign w_slot = w_start + r_cnt[WORD_W-1:0];
    assign w_beat = (r_state == S_DATA) && rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_line  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_valid) begin
                        r_addr  <= miss_addr;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (grnt) r_state <= S_ADDR;
                end
                S_ADDR: begin
                    if (arready) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (r_cnt != FULL_CNT) begin
                            r_line[w_slot*32 +: 32] <= rdata;
                            r_cnt                   <= r_cnt + 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (rresp != 2'b00) r_err <= 1'b1;
                        // rlast must coincide with the final slot; anything else is a length mismatch.
                        if (rlast) begin
                            if (r_cnt != LAST_CNT) r_err <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign miss_ready  = (r_state == S_IDLE);
    assign req         = (r_state == S_REQ) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign arvalid     = (r_state == S_ADDR);
    assign rready      = (r_state == S_DATA);
    assign refill_done = (r_state == S_DONE);
    assign refill_err  = (r_state == S_DONE) && r_err;
    assign refill_line = r_line;

    assign arid    = ARID_VAL;
    assign arlen   = 4'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

`ifdef CRITICAL_WORD_FIRST_EN
    assign crit_valid = w_beat && (r_cnt == '0);
    assign crit_data  = rdata;
`endif

endmodule

// File: tb/tb_axi_cache_refill_master.sv
// Randomized bench for axi_cache_refill_master with a transaction-level line/err model and per-cycle output checks.
module tb_axi_cache_refill_master;
    localparam int LW    = 8;
    localparam int OFF_W = $clog2(LW * 4);
    localparam int NMAX  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, miss_valid, miss_ready, refill_done, refill_err;
    logic [31:0]        miss_addr;
    logic [32*LW-1:0]   refill_line;
    logic               req, grnt, arvalid, arready, rlast, rvalid, rready;
    logic [3:0]         arid, arlen, arcache, rid;
    logic [31:0]        araddr, rdata;
    logic [2:0]         arsize, arprot;
    logic [1:0]         arburst, arlock, rresp;
`ifdef CRITICAL_WORD_FIRST_EN
    logic               crit_valid;
    logic [31:0]        crit_data;
    logic               exp_crit;
    logic [31:0]        exp_crit_data;
`endif

    axi_cache_refill_master #(.LINE_WORDS(LW), .ARID_VAL(4'h0)) dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
        .miss_ready(miss_ready), .refill_done(refill_done), .refill_line(refill_line),
        .refill_err(refill_err),
`ifdef CRITICAL_WORD_FIRST_EN
        .crit_valid(crit_valid), .crit_data(crit_data),
`endif
        .req(req), .grnt(grnt), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready), .rid(rid),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int checks = 0;
    int errors = 0;

    logic             chk_en = 1'b0;
    logic             exp_req, exp_arvalid, exp_rready, exp_mr, exp_done, exp_err;
    logic [31:0]      exp_araddr;
    logic [32*LW-1:0] m_line;
    logic [31:0]      last_araddr = '0;
    logic             last_err = 1'bx;
    logic [32*LW-1:0] last_line = '0;

    logic [31:0] bdata [NMAX];
    logic [1:0]  bresp [NMAX];
    int          bgap  [NMAX];
    int          nb;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_exp(input logic r, input logic a, input logic rr, input logic mr, input logic d);
        exp_req = r; exp_arvalid = a; exp_rready = rr; exp_mr = mr; exp_done = d;
`ifdef CRITICAL_WORD_FIRST_EN
        exp_crit = 1'b0;
`endif
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", 256'(req), 256'(exp_req));
            chk("arvalid", 256'(arvalid), 256'(exp_arvalid));
            chk("rready", 256'(rready), 256'(exp_rready));
            chk("miss_ready", 256'(miss_ready), 256'(exp_mr));
            chk("refill_done", 256'(refill_done), 256'(exp_done));
            if (exp_arvalid) begin
                chk("araddr", 256'(araddr), 256'(exp_araddr));
                chk("arlen", 256'(arlen), 256'(LW - 1));
                chk("arsize", 256'(arsize), 256'(2));
`ifdef CRITICAL_WORD_FIRST_EN
                chk("arburst", 256'(arburst), 256'(2'b10));
`else
                chk("arburst", 256'(arburst), 256'(2'b01));
`endif
                chk("ar_const", 256'({arid, arlock, arcache, arprot}), 256'(0));
                last_araddr = araddr;
            end
            if (exp_done) begin
                chk("refill_err", 256'(refill_err), 256'(exp_err));
                chk("line_done", 256'(refill_line), 256'(m_line));
                last_err  = refill_err;
                last_line = refill_line;
            end
            if (exp_mr) chk("line_hold", 256'(refill_line), 256'(m_line));
`ifdef CRITICAL_WORD_FIRST_EN
            chk("crit_valid", 256'(crit_valid), 256'(exp_crit));
            if (exp_crit) chk("crit_data", 256'(crit_data), 256'(exp_crit_data));
`endif
        end
    end

    // One full miss transaction; rst_after >= 0 resets the DUT after that many accepted beats.
    task automatic run(input logic [31:0] addr, input int gw, input int aw, input int rst_after);
        int start;
        int slot;
`ifdef CRITICAL_WORD_FIRST_EN
        exp_araddr = {addr[31:2], 2'b00};
        start      = int'(addr[OFF_W-1:2]);
`else
        exp_araddr = {addr[31:OFF_W], OFF_W'(0)};
        start      = 0;
`endif
        exp_err = 1'b0;
        for (int k = 0; k < nb; k++) if (bresp[k] != 2'b00) exp_err = 1'b1;
        if (nb != LW) exp_err = 1'b1;

        miss_valid = 1'b1; miss_addr = addr;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i <= gw; i++) begin
            grnt = (i == gw);
            miss_valid = 1'($urandom); miss_addr = $urandom;
            rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b11;
            set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        for (int i = 0; i <= aw; i++) begin
            arready = (i == aw);
            miss_valid = 1'($urandom);
            set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        arready = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (k == rst_after) begin
                rst = 1'b1; rvalid = 1'b0; rlast = 1'b0; miss_valid = 1'b0;
                set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                @(posedge clk); #1;
                rst = 1'b0; grnt = 1'b0;
                m_line = '0;
                set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                return;
            end
            for (int g = 0; g < bgap[k]; g++) begin
                rvalid = 1'b0; rlast = 1'b0; rdata = $urandom;
                set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                @(posedge clk); #1;
            end
            rvalid = 1'b1; rdata = bdata[k]; rresp = bresp[k]; rlast = (k == nb - 1);
            rid = 4'($urandom);
            set_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef CRITICAL_WORD_FIRST_EN
            exp_crit = (k == 0); exp_crit_data = bdata[k];
`endif
            @(posedge clk); #1;
            if (k < LW) begin
                slot = (start + k) % LW;
                m_line[slot*32 +: 32] = bdata[k];
            end
        end
        rvalid = 1'b0; rlast = 1'b0; grnt = 1'b0; miss_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic fill_beats(input int n, input int gapmode);
        nb = n;
        for (int k = 0; k < NMAX; k++) begin
            bdata[k] = 32'hA0 + k;
            bresp[k] = 2'b00;
            bgap[k]  = (gapmode == 1 && k > 0) ? 2 : 0;
        end
    endtask

    logic [32*LW-1:0] lit;

    initial begin
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; grnt = 1'b0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        m_line = '0; exp_err = 1'b0; exp_araddr = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_line", 256'(refill_line), 256'(0));

        // Nominal refill
        fill_beats(LW, 0);
        run(32'h1000_0014, 0, 0, -1);
        for (int i = 0; i < LW; i++)
`ifdef CRITICAL_WORD_FIRST_EN
            lit[i*32 +: 32] = 32'hA0 + ((i + LW - 5) % LW);
        chk("lit_araddr", 256'(last_araddr), 256'(32'h1000_0014));
`else
            lit[i*32 +: 32] = 32'hA0 + i;
        chk("lit_araddr", 256'(last_araddr), 256'(32'h1000_0000));
`endif
        chk("lit_line", 256'(last_line), 256'(lit));
        chk("lit_err0", 256'(last_err), 256'(0));

        // Grant and address stalls
        fill_beats(LW, 0);
        for (int k = 0; k < LW; k++) bdata[k] = $urandom;
        run(32'h2000_0040, 5, 3, -1);
        chk("lit_araddr_stall", 256'(last_araddr), 256'(32'h2000_0040));

        // Backpressure gaps
        fill_beats(LW, 1);
        run(32'h3000_0008, 1, 1, -1);

        // Error response on beat 3
        fill_beats(LW, 0);
        bresp[2] = 2'b10;
        run(32'h4000_0000, 0, 0, -1);
        chk("lit_err_resp", 256'(last_err), 256'(1));

        // Short burst
        fill_beats(6, 0);
        run(32'h5000_0020, 0, 2, -1);
        chk("lit_err_short", 256'(last_err), 256'(1));

        // Reset during DATA after 4 beats, then a clean refill
        fill_beats(LW, 0);
        run(32'h6000_0000, 0, 0, 4);
        chk("rst_line", 256'(refill_line), 256'(0));
        fill_beats(LW, 0);
        run(32'h7000_001C, 2, 0, -1);
        chk("lit_err_after_rst", 256'(last_err), 256'(0));

        // Randomized refills
        for (int t = 0; t < 40; t++) begin
            nb = ($urandom % 4 == 0) ? int'($urandom_range(1, LW + 3)) : LW;
            for (int k = 0; k < NMAX; k++) begin
                bdata[k] = $urandom;
                bresp[k] = ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                bgap[k]  = int'($urandom % 3);
            end
            run($urandom, int'($urandom % 4), int'($urandom % 4),
                ($urandom % 8 == 0) ? int'($urandom % nb) : -1);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_cache_refill_master.md
Name: axi_cache_refill_master

Overview:
- Cache-line refill engine for one master port of the shared cache read bus.
- Sits directly upstream of the three-master cache load bus, e.g. as the I-cache or D-cache miss handler.
- Accepts a miss address from the cache and requests bus ownership (req/grnt).
- Issues one AXI read burst for the whole line, collects the beats into a line buffer, and returns the line with a done pulse.

Parameters:
- LINE_WORDS, 8: 32-bit words per cache line; power of two, 2..16.
- ARID_VAL, 4'h0: constant value driven on arid.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  cache requests a refill
- miss_addr  in  32  miss byte address, valid with miss_valid
- miss_ready  out  1  high only in IDLE; miss accepted when miss_valid & miss_ready
- refill_done  out  1  one-cycle pulse; refill_line/refill_err valid this cycle
- refill_line  out  32*LINE_WORDS  word i at bits [32i+31:32i], i = word offset within line
- refill_err  out  1  valid with refill_done; any rresp!=0 or beat-count mismatch
- req  out  1  bus request to arbiter
- grnt  in  1  bus grant from arbiter
- arid  out  4  = ARID_VAL
- araddr  out  32  burst start address
- arlen  out  4  = LINE_WORDS-1
- arsize  out  3  = 3'b010
- arburst  out  2  = 2'b01 (INCR); see Optional Feature
- arlock  out  2  = 0
- arcache  out  4  = 0
- arprot  out  3  = 0
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  response
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  data ready

Behaviour:
- Reset: state=IDLE; req, arvalid, rready, refill_done, refill_err = 0; refill_line = 0; beat counter = 0; miss_ready = 1 in the cycle after reset is released. Reset mid-operation aborts immediately; no outstanding-transaction tracking.
- FSM states: IDLE, REQ, ADDR, DATA, DONE.
- IDLE: on miss_valid, latch miss_addr, clear err flag and beat counter, go to REQ.
- REQ: req=1. When grnt=1 is sampled, go to ADDR. grnt is sampled only in this state; the arbiter holds the grant while req is high.
- ADDR: req=1, arvalid=1, araddr stable. On arvalid & arready, go to DATA.
  - araddr = latched address with the low log2(LINE_WORDS*4) bits cleared.
- DATA: req=1, rready=1.
  - Each rvalid beat writes rdata into word slot (start_word + cnt) mod LINE_WORDS, then cnt increments.
  - rresp!=0 on any beat sets the err flag.
  - On a beat with rlast=1: set the err flag if cnt != LINE_WORDS-1, then go to DONE.
  - Beats arriving after cnt has reached LINE_WORDS are not stored; they set the err flag.
- DONE: req=0, refill_done=1 for exactly one cycle, refill_err = err flag, then IDLE.
  - refill_line holds its value until the next refill begins.
- Latencies:
  - Minimum miss acceptance to arvalid: 2 cycles (grnt already high).
  - refill_done asserts the cycle after the rlast beat.
  - req deasserts the cycle after the rlast beat, releasing the bus.
- Handshake rules:
  - arvalid never drops before arready; araddr/arlen are stable while arvalid=1.
  - rready is asserted only in DATA.
- miss_valid outside IDLE is ignored (miss_ready=0).

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - arburst = 2'b10 (WRAP).
  - araddr = latched address with bits [1:0] cleared (critical word first).
  - start_word = addr[log2(LINE_WORDS*4)-1:2]; beat k goes to slot (start_word+k) mod LINE_WORDS.
  - Additional output crit_valid (1 bit) pulses with the first data beat, and crit_data (32 bits) carries that beat's rdata.
- Undefined:
  - INCR burst from the line base, start_word = 0.
  - crit_valid and crit_data ports are absent.

Test Plan:
- Nominal refill (LINE_WORDS=8): miss_addr=0x1000_0014, grnt high, arready immediate, 8 beats rdata=0xA0..0xA7, rlast on beat 8 -> araddr=0x1000_0000, arlen=7, arsize=2, refill_done after 8th beat, refill_line word i = 0xA0+i, refill_err=0.
- Grant and address stall: grnt low for 5 cycles, then arready low for 3 cycles -> req held throughout, arvalid held 4 cycles with araddr stable, no beats accepted before the AR handshake.
- Backpressure gaps: rvalid toggling 1,0,0,1,... -> all 8 words captured in order, refill_done exactly one cycle, req drops the same cycle.
- Error response: rresp=2'b10 on beat 3 -> refill_err=1 with refill_done, all 8 words still stored.
- Short burst: rlast on beat 6 -> refill_done the next cycle with refill_err=1, FSM back in IDLE, miss_ready=1.
- Reset during DATA after 4 beats -> next cycle req=0, rready=0, refill_done=0, miss_ready=1; a new miss completes normally.
- With CRITICAL_WORD_FIRST_EN: miss_addr=0x1000_0014 -> arburst=2'b10, araddr=0x1000_0014, crit_data = first beat, first beat lands in word 5, then words 6,7,0,...,4.
